uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-port byte arbiter for a UART transmitter. Ports A (CPU) and B (debug) each
// queue bytes in a small circular FIFO; a round-robin FSM hands one byte at a time to the transmitter.

module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [DW-1:0] data,
    input  logic          rd,
    input  logic          ovf_clr,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic          ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wptr_r, rptr_r;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          full_r, empty_r, ovf_r;
    logic          push_s, pop_s, ovf_evt_s;

    // Fullness is judged before any same-cycle pop, so a push at full is always dropped.
    assign push_s    = wr & (cnt_r != FULL_CNT);
    assign ovf_evt_s = wr & (cnt_r == FULL_CNT);
    assign pop_s     = rd & (cnt_r != {CW{1'b0}});
    assign head      = mem_r[rptr_r];
    assign full      = full_r;
    assign empty     = empty_r;
    assign ovf       = ovf_r;

    // Next occupancy count from accepted push and pop.
    always_comb begin
        cnt_s = cnt_r;
        if (push_s && !pop_s) begin
            cnt_s = cnt_r + CW'(1);
        end else if (!push_s && pop_s) begin
            cnt_s = cnt_r - CW'(1);
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wptr_r] <= data;
        end
    end

    // Pointers, count, registered flags and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r  <= {PW{1'b0}};
            rptr_r  <= {PW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            ovf_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PW'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PW'(1);
            end
            cnt_r   <= cnt_s;
            full_r  <= (cnt_s == FULL_CNT);
            empty_r <= (cnt_s == {CW{1'b0}});
            // A new overflow outranks a simultaneous clear.
            ovf_r   <= (ovf_r & ~ovf_clr) | ovf_evt_s;
        end
    end
endmodule

module uart_tx_arbiter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       i_Clock,
    input  logic       reset_n,
    input  logic       a_wr,
    input  logic [7:0] a_data,
    input  logic       b_wr,
    input  logic [7:0] b_data,
    output logic       a_full,
    output logic       b_full,
    output logic       a_empty,
    output logic       b_empty,
    output logic       a_ovf,
    output logic       b_ovf,
    input  logic       ovf_clr,
    output logic       tx_dv,
    output logic [7:0] tx_byte,
    input  logic       tx_active,
    input  logic       tx_done,
    output logic       busy,
    output logic       grant_b
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t     state_r, state_s;
    logic       rst_done_r;
    logic       grant_s, sel_b_s, pop_a_s, pop_b_s;
    logic [7:0] a_head_s, b_head_s;
    logic       tx_dv_r, busy_r, grant_b_r;
    logic [7:0] tx_byte_r;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .DW(8)) u_fifo_a (
        .clk(i_Clock), .rst_n(reset_n), .wr(a_wr), .data(a_data), .rd(pop_a_s),
        .ovf_clr(ovf_clr), .head(a_head_s), .full(a_full), .empty(a_empty), .ovf(a_ovf)
    );

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .DW(8)) u_fifo_b (
        .clk(i_Clock), .rst_n(reset_n), .wr(b_wr), .data(b_data), .rd(pop_b_s),
        .ovf_clr(ovf_clr), .head(b_head_s), .full(b_full), .empty(b_empty), .ovf(b_ovf)
    );

    assign pop_a_s = grant_s & ~sel_b_s;
    assign pop_b_s = grant_s & sel_b_s;
    assign tx_dv   = tx_dv_r;
    assign tx_byte = tx_byte_r;
    assign busy    = busy_r;
    assign grant_b = grant_b_r;

    // Next-state and grant decision; B wins a tie only if A was granted last.
    always_comb begin
        state_s = state_r;
        grant_s = 1'b0;
        sel_b_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rst_done_r && !tx_done && !tx_active && (!a_empty || !b_empty)) begin
                    grant_s = 1'b1;
                    sel_b_s = !b_empty && (a_empty || !grant_b_r);
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (tx_done) begin
                    state_s = ST_RELEASE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RELEASE: begin
                if (!tx_done) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RELEASE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered transmitter-side outputs; rst_done_r delays the first grant one edge.
    always_ff @(posedge i_Clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            rst_done_r <= 1'b0;
            tx_dv_r    <= 1'b0;
            tx_byte_r  <= 8'h00;
            busy_r     <= 1'b0;
            grant_b_r  <= 1'b1;
        end else begin
            state_r    <= state_s;
            rst_done_r <= 1'b1;
            tx_dv_r    <= (state_s == ST_WAIT);
            busy_r     <= (state_s != ST_IDLE);
            if (grant_s) begin
                tx_byte_r <= sel_b_s ? b_head_s : a_head_s;
                grant_b_r <= sel_b_s;
            end
        end
    end
endmodule
